// File: rtl/vote_result_scanner.sv
// Snapshots per-candidate vote tallies on start, scans them one per cycle and
// presents winner/tie/total under valid/ready. Optional LED hold: VRS_LED_HOLD_EN.
module vote_result_scanner #(
    parameter int NUM_CAND    = 4,
    parameter int CNT_W       = 8,
    parameter int HOLD_CYCLES = 10
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic [NUM_CAND*CNT_W-1:0]          cnt_flat,
    input  logic                               res_ready,
    output logic                               busy,
    output logic                               res_valid,
    output logic [$clog2(NUM_CAND)-1:0]        winner_idx,
    output logic [CNT_W-1:0]                   winner_cnt,
    output logic                               tie,
    output logic [CNT_W+$clog2(NUM_CAND)-1:0]  total,
    output logic [7:0]                         led
);

    localparam int IDX_W = $clog2(NUM_CAND);
    localparam int TOT_W = CNT_W + IDX_W;
    localparam int LED_W = (CNT_W < 8) ? CNT_W : 8;

    typedef enum logic [1:0] {IDLE, SCAN, PRESENT} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    snap_q [NUM_CAND];
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    best_q, best_d;
    logic [IDX_W-1:0]    widx_q, widx_d;
    logic                tie_q, tie_d;
    logic [TOT_W-1:0]    total_q, total_d;
    logic                load_snap;
    logic                handshake;
    logic [CNT_W-1:0]    cur;
    logic [7:0]          led_q;

    // Low byte of a tally, zero-extended when tallies are narrower than 8 bits.
    function automatic logic [7:0] led_byte(input logic [CNT_W-1:0] v);
        logic [7:0] r;
        r = '0;
        r[LED_W-1:0] = v[LED_W-1:0];
        return r;
    endfunction

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        best_d    = best_q;
        widx_d    = widx_q;
        tie_d     = tie_q;
        total_d   = total_q;
        load_snap = 1'b0;
        handshake = 1'b0;
        cur       = snap_q[idx_q];
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = SCAN;
                    load_snap = 1'b1;
                    idx_d     = '0;
                    best_d    = '0;
                    widx_d    = '0;
                    tie_d     = 1'b0;
                    total_d   = '0;
                end
            end
            SCAN: begin
                total_d = total_q + TOT_W'(cur);
                if (idx_q == '0) begin
                    best_d = cur;
                    widx_d = '0;
                    tie_d  = 1'b0;
                end else if (cur > best_q) begin
                    best_d = cur;
                    widx_d = idx_q;
                    tie_d  = 1'b0;
                end else if (cur == best_q) begin
                    // Lowest index keeps the win on equal tallies.
                    tie_d = 1'b1;
                end
                if (idx_q == IDX_W'(NUM_CAND - 1)) begin
                    state_d = PRESENT;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            PRESENT: begin
                if (res_ready) begin
                    handshake = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            best_q  <= '0;
            widx_q  <= '0;
            tie_q   <= 1'b0;
            total_q <= '0;
            for (int i = 0; i < NUM_CAND; i++) snap_q[i] <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            best_q  <= best_d;
            widx_q  <= widx_d;
            tie_q   <= tie_d;
            total_q <= total_d;
            if (load_snap) begin
                for (int i = 0; i < NUM_CAND; i++) snap_q[i] <= cnt_flat[i*CNT_W +: CNT_W];
            end
        end
    end

`ifdef VRS_LED_HOLD_EN
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    logic [HOLD_W-1:0] hold_q;

    // The hold counter runs on its own, so a new scan may overlap the display.
    always_ff @(posedge clk) begin
        if (!reset) begin
            led_q  <= 8'h00;
            hold_q <= '0;
        end else if (handshake) begin
            led_q  <= led_byte(best_q);
            hold_q <= HOLD_W'(HOLD_CYCLES - 1);
        end else if (hold_q != '0) begin
            hold_q <= hold_q - HOLD_W'(1);
        end else begin
            led_q <= 8'h00;
        end
    end

    assign led = (state_q == PRESENT) ? 8'h00 : led_q;
`else
    always_ff @(posedge clk) begin
        if (!reset) begin
            led_q <= 8'h00;
        end else begin
            led_q <= (state_d == PRESENT) ? led_byte(best_d) : 8'h00;
        end
    end

    assign led = led_q;
`endif

    assign busy       = (state_q != IDLE);
    assign res_valid  = (state_q == PRESENT);
    assign winner_idx = widx_q;
    assign winner_cnt = best_q;
    assign tie        = tie_q;
    assign total      = total_q;

endmodule
